// File: rtl/tv80_arb_pkg.sv
// Shared types and helpers for the TV80 bus arbiter and its round-robin picker.
package tv80_arb_pkg;

    // Largest requester count the arbiter is built for.
    localparam int ARB_MAX_REQ = 8;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int arb_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tv80_rr_pick.sv
// Combinational round-robin picker: the search starts at (i_ptr+1) mod NREQ
// and wraps, so the previous winner has the lowest priority.
module tv80_rr_pick
    import tv80_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = arb_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Walk from lowest to highest priority so the highest-priority hit is the last write.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_cand = IDX_W'((int'(i_ptr) + off) % NREQ);
            if (i_req[w_cand]) begin
                o_onehot         = '0;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
                o_any            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tv80_bus_arbiter.sv
// Round-robin arbiter sharing the TV80 bus with DMA-style requesters through
// the busrq_n/busak_n handshake. Every grant is followed by a forced CPU
// ownership window (RELEASE, optional GAP, IDLE) so the CPU is never starved.
module tv80_bus_arbiter
    import tv80_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CPU_GAP  = 4,
    parameter int MAX_HOLD = 0,
    parameter int IDX_W    = arb_width(NREQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cen,
    input  logic [NREQ-1:0]  req,
    input  logic             busak_n,
    output logic             busrq_n,
    output logic [NREQ-1:0]  gnt,
    output logic             bus_own,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             hold_expired
);

    localparam int HOLD_W = arb_width(MAX_HOLD);
    localparam int GAP_W  = arb_width(CPU_GAP);
    // Terminal counts: the counter value seen on the last tick of the window.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CPU_GAP > 0) ? CPU_GAP - 1 : 0);

    // Registered state. The round-robin pointer doubles as gnt_idx, since
    // both always name the current or most recent grantee.
    arb_state_t        r_state;
    logic              r_busrq_n;
    logic [NREQ-1:0]   r_gnt;
    logic              r_bus_own;
    logic [IDX_W-1:0]  r_ptr;
    logic              r_hold_expired;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;

    arb_state_t        w_state_next;
    logic              w_busrq_n_next;
    logic [NREQ-1:0]   w_gnt_next;
    logic              w_bus_own_next;
    logic [IDX_W-1:0]  w_ptr_next;
    logic              w_hold_expired_next;
    logic [HOLD_W-1:0] w_hold_cnt_next;
    logic [GAP_W-1:0]  w_gap_cnt_next;

    logic [NREQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_leave;
    logic              w_expire;

    tv80_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // State register; everything advances only on cen ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_busrq_n      <= 1'b1;
            r_gnt          <= '0;
            r_bus_own      <= 1'b0;
            r_ptr          <= '0;
            r_hold_expired <= 1'b0;
            r_hold_cnt     <= '0;
            r_gap_cnt      <= '0;
        end else if (cen) begin
            r_state        <= w_state_next;
            r_busrq_n      <= w_busrq_n_next;
            r_gnt          <= w_gnt_next;
            r_bus_own      <= w_bus_own_next;
            r_ptr          <= w_ptr_next;
            r_hold_expired <= w_hold_expired_next;
            r_hold_cnt     <= w_hold_cnt_next;
            r_gap_cnt      <= w_gap_cnt_next;
        end
    end

    // Next-state and next-output logic for the arbitration handshake.
    always_comb begin
        w_state_next        = r_state;
        w_busrq_n_next      = r_busrq_n;
        w_gnt_next          = r_gnt;
        w_bus_own_next      = r_bus_own;
        w_ptr_next          = r_ptr;
        w_hold_expired_next = 1'b0;
        w_hold_cnt_next     = r_hold_cnt;
        w_gap_cnt_next      = r_gap_cnt;
        w_expire            = 1'b0;
        w_leave             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_busrq_n_next = 1'b0;
                    w_state_next   = ST_REQ;
                end
            end

            ST_REQ: begin
                // No timeout: the CPU finishes its M-cycle before acknowledging.
                if (!busak_n) begin
                    if (w_pick_any) begin
                        w_gnt_next      = w_pick_onehot;
                        w_bus_own_next  = 1'b1;
                        w_ptr_next      = w_pick_idx;
                        w_hold_cnt_next = '0;
                        w_state_next    = ST_GRANT;
                    end else begin
                        // Requests were withdrawn: hand the bus straight back.
                        w_busrq_n_next = 1'b1;
                        w_state_next   = ST_RELEASE;
                    end
                end
            end

            ST_GRANT: begin
                // A requester dropping its bit takes precedence over expiry.
                if (!req[r_ptr]) begin
                    w_leave = 1'b1;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
                    w_leave  = 1'b1;
                    w_expire = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end

                if (w_leave) begin
                    w_gnt_next          = '0;
                    w_bus_own_next      = 1'b0;
                    w_busrq_n_next      = 1'b1;
                    w_hold_cnt_next     = '0;
                    w_hold_expired_next = w_expire;
                    w_state_next        = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (busak_n) begin
                    w_gap_cnt_next = '0;
                    w_state_next   = (CPU_GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end

            ST_GAP: begin
                // Requests are ignored here; the CPU keeps the bus for CPU_GAP ticks.
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busrq_n      = r_busrq_n;
    assign gnt          = r_gnt;
    assign bus_own      = r_bus_own;
    assign gnt_idx      = r_ptr;
    assign hold_expired = r_hold_expired;

endmodule
